// File: rtl/sample_serializer_if.sv
// Sample handshake from the decay stage, plus the serial pins and status toward the codec side.
interface sample_serializer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int LEVEL_W      = 3
);
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_ready;
  logic                    bclk;
  logic                    lrclk;
  logic                    sdata;
  logic [LEVEL_W-1:0]      fifo_level;
  logic                    overflow;
  logic                    underflow;

  // Producer side: drives samples, observes the stream and status.
  modport master (
    output sample_in, sample_ready,
    input  bclk, lrclk, sdata, fifo_level, overflow, underflow
  );

  // Serializer side: consumes samples, drives the stream and status.
  modport slave (
    input  sample_in, sample_ready,
    output bclk, lrclk, sdata, fifo_level, overflow, underflow
  );
endinterface

// File: rtl/sample_serializer.sv
// sample_serializer: buffers mono samples in a small FIFO and sends each one on both channels
// of a left-justified serial stream (bclk/lrclk/sdata), MSB first.
module sample_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int BCLK_DIV     = 4
) (
  input  logic               clk,
  input  logic               reset,
  sample_serializer_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SLOT_W  = $clog2(2 * SAMPLE_WIDTH);
  localparam int MSB     = SAMPLE_WIDTH - 1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [LEVEL_W-1:0]      r_level;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [SLOT_W-1:0]       r_bit_cnt;
  logic [DIV_W-1:0]        r_div_cnt;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_overflow;
  logic                    r_underflow;

  logic                    w_load_first;
  logic                    w_div_term;
  logic                    w_bclk_fall;
  logic                    w_half_end;
  logic                    w_frame_end;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic [SLOT_W-1:0]       w_bit_cnt_inc;
  logic [SAMPLE_WIDTH-1:0] w_head;
  logic [SAMPLE_WIDTH-1:0] w_frame_sample;

  assign w_head         = r_mem[r_rd_ptr];
  assign w_empty        = (r_level == '0);
  assign w_full         = (r_level == LEVEL_W'(FIFO_DEPTH));
  assign w_div_term     = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_bclk_fall    = (r_state == ST_RUN) && r_bclk && w_div_term;
  assign w_half_end     = w_bclk_fall && (r_bit_cnt == SLOT_W'(SAMPLE_WIDTH - 1));
  assign w_frame_end    = w_bclk_fall && (r_bit_cnt == '1);
  assign w_bit_cnt_inc  = r_bit_cnt + SLOT_W'(1);
  // A frame boundary with nothing buffered sends silence instead of stalling the stream.
  assign w_pop          = w_load_first || (w_frame_end && !w_empty);
  // A full FIFO still accepts a write when the same cycle frees an entry.
  assign w_push         = bus.sample_ready && (!w_full || w_pop);
  assign w_frame_sample = w_empty ? '0 : w_head;

  // State register: IDLE until two samples are buffered, then RUN until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and the one-shot load that starts the stream.
  always_comb begin
    w_state_next = r_state;
    w_load_first = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level >= LEVEL_W'(2)) begin
          w_state_next = ST_RUN;
          w_load_first = 1'b1;
        end
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.sample_in;
  end

  // FIFO pointers, occupancy and the overflow/underflow status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.sample_ready && w_full && !w_pop;
      r_underflow <= w_frame_end && w_empty;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LEVEL_W'(1);
      else if (w_pop && !w_push) r_level <= r_level - LEVEL_W'(1);
    end
  end

  // Bit clock divider, slot counter and shift register; data moves only on bclk falling edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample  <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
    end else if (w_load_first) begin
      r_sample  <= w_frame_sample;
      r_shift   <= w_frame_sample;
      r_sdata   <= w_frame_sample[MSB];
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_div_term) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      if (w_bclk_fall) begin
        r_bit_cnt <= w_bit_cnt_inc;
        r_lrclk   <= w_bit_cnt_inc[SLOT_W-1];
        if (w_frame_end) begin
          r_sample <= w_frame_sample;
          r_shift  <= w_frame_sample;
          r_sdata  <= w_frame_sample[MSB];
        end else if (w_half_end) begin
          // Right channel repeats the held sample from its sign bit.
          r_shift <= r_sample;
          r_sdata <= r_sample[MSB];
        end else begin
          r_shift <= r_shift << 1;
          r_sdata <= r_shift[MSB-1];
        end
      end
    end
  end

  assign bus.bclk       = r_bclk;
  assign bus.lrclk      = r_lrclk;
  assign bus.sdata      = r_sdata;
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;
endmodule

// File: tb/tb_sample_serializer.sv
// Testbench for sample_serializer: directed scenarios plus randomized strobes, checked every
// clock against a frame-level reference model (sample queue + clock-count arithmetic).
module tb_sample_serializer;
  localparam int SW        = 16;
  localparam int DEPTH     = 4;
  localparam int DIV       = 4;
  localparam int BITCLK    = 2 * DIV;          // clk per bclk period
  localparam int FRAME_CLK = 2 * SW * BITCLK;  // clk per 32-slot frame

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sample_serializer_if #(.SAMPLE_WIDTH(SW), .LEVEL_W(3)) bus ();

  sample_serializer #(
    .SAMPLE_WIDTH(SW),
    .FIFO_DEPTH  (DEPTH),
    .BCLK_DIV    (DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [SW-1:0] q[$];
  bit            m_run;
  int            m_fcnt;      // clk edges since the current frame started
  logic [SW-1:0] m_cur;       // sample carried by the current frame
  bit            exp_ovf;
  bit            exp_unf;

  // Stream capture state
  logic          prev_bclk;
  logic [31:0]   cap_data;
  logic [31:0]   cap_lr;
  int            cap_n;
  int            n_frames;
  longint        cyc;
  longint        last_frame_cyc;
  int            ovf_seen;
  int            unf_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic m_clear();
    q.delete();
    m_run          = 1'b0;
    m_fcnt         = 0;
    m_cur          = '0;
    exp_ovf        = 1'b0;
    exp_unf        = 1'b0;
    prev_bclk      = 1'b0;
    cap_n          = 0;
    last_frame_cyc = -1;
  endtask

  // Advance the model across one clock edge using the inputs presented before that edge.
  task automatic m_step(input bit rdy, input logic [SW-1:0] d);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (reset) return;
    if (!m_run) begin
      if (q.size() >= 2) begin
        m_run          = 1'b1;
        m_fcnt         = 0;
        m_cur          = q.pop_front();
        cap_n          = 0;
        last_frame_cyc = -1;
      end
    end else begin
      m_fcnt++;
      if (m_fcnt == FRAME_CLK) begin
        m_fcnt = 0;
        if (q.size() > 0) m_cur = q.pop_front();
        else begin
          m_cur   = '0;
          exp_unf = 1'b1;
        end
      end
    end
    if (rdy) begin
      if (q.size() < DEPTH) q.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic post_check();
    int         slot;
    logic [2:0] exp_pins;
    chk("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
    chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
    chk("underflow", 32'(bus.underflow), 32'(exp_unf));
    if (bus.overflow)  ovf_seen++;
    if (bus.underflow) unf_seen++;
    if (!m_run) begin
      chk("idle_pins", 32'({bus.bclk, bus.lrclk, bus.sdata}), 32'd0);
    end else begin
      slot     = m_fcnt / BITCLK;
      exp_pins = {((m_fcnt % BITCLK) >= DIV), (slot >= SW), m_cur[SW-1 - (slot % SW)]};
      chk("serial_pins", 32'({bus.bclk, bus.lrclk, bus.sdata}), 32'(exp_pins));
      if (!prev_bclk && bus.bclk) begin
        cap_data = {cap_data[30:0], bus.sdata};
        cap_lr   = {cap_lr[30:0], bus.lrclk};
        cap_n++;
        if (cap_n == 2 * SW) begin
          n_frames++;
          $display("frame %0d: left=%04h right=%04h lrclk=%08h", n_frames,
                   cap_data[31:16], cap_data[15:0], cap_lr);
          chk("frame_data", cap_data, {m_cur, m_cur});
          chk("frame_lrclk", cap_lr, 32'h0000FFFF);
          if (last_frame_cyc >= 0) chk("frame_period", 32'(cyc - last_frame_cyc), 32'(FRAME_CLK));
          last_frame_cyc = cyc;
          cap_n = 0;
        end
      end
    end
    prev_bclk = bus.bclk;
  endtask

  task automatic tick(input bit rdy, input logic [SW-1:0] d);
    bus.sample_ready = rdy;
    bus.sample_in    = d;
    m_step(rdy, d);
    @(posedge clk);
    cyc++;
    #1;
    post_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, SW'($urandom));
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input int hold);
    #2;
    reset = 1'b1;
    #1;
    m_clear();
    chk("async_reset_outputs",
        32'({bus.bclk, bus.lrclk, bus.sdata, bus.overflow, bus.underflow, bus.fifo_level}), 32'd0);
    for (int i = 0; i < hold; i++) tick(1'b0, '0);
    reset = 1'b0;
  endtask

  task automatic wait_fcnt(input int target, input string tag);
    int guard = 0;
    while (!(m_run && m_fcnt == target) && guard < 2 * FRAME_CLK) begin
      tick(1'b0, '0);
      guard++;
    end
    chk(tag, 32'(guard < 2 * FRAME_CLK), 32'd1);
  endtask

  initial begin
    int ovf_before;
    int unf_before;
    int rate;
    logic [15:0] t3_vals [3];
    t3_vals[0] = 16'h8000;
    t3_vals[1] = 16'h7FFF;
    t3_vals[2] = 16'h0001;

    bus.sample_ready = 1'b0;
    bus.sample_in    = '0;
    cyc              = 0;
    n_frames         = 0;
    ovf_seen         = 0;
    unf_seen         = 0;
    cap_data         = '0;
    cap_lr           = '0;
    m_clear();

    // Reset 8 clk, then 500 clk of silence: pins stay low, stream stays idle.
    for (int i = 0; i < 8; i++) tick(1'b0, '0);
    reset = 1'b0;
    idle(500);

    // Two 0x0888 samples start the stream; then three samples paced one per frame.
    tick(1'b1, 16'h0888);
    tick(1'b1, 16'h0888);
    unf_before = unf_seen;
    idle(250);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, t3_vals[i]);
      idle(255);
    end
    chk("paced_no_underflow", 32'(unf_seen - unf_before), 32'd0);

    // Stream runs dry: a silent frame with one underflow, then 0x1234 resumes it.
    idle(300);
    chk("dry_underflow_once", 32'(unf_seen - unf_before), 32'd1);
    tick(1'b1, 16'h1234);
    idle(300);

    // Six back-to-back strobes into an empty FIFO mid-frame: saturates, two dropped.
    wait_fcnt(100, "reach_midframe");
    ovf_before = ovf_seen;
    for (int i = 1; i <= 6; i++) tick(1'b1, 16'(i));
    chk("burst_level_sat", 32'(bus.fifo_level), 32'd4);
    chk("burst_overflows", 32'(ovf_seen - ovf_before), 32'd2);
    idle(5 * FRAME_CLK);

    // Reset at slot 10 mid-frame; stream then waits for two fresh samples.
    wait_fcnt(10 * BITCLK + 2, "reach_slot10");
    async_reset(3);
    tick(1'b1, 16'hA5C3);
    idle(300);
    chk("one_sample_stays_idle", 32'(m_run), 32'd0);
    tick(1'b1, 16'h3C5A);
    idle(2 * FRAME_CLK + 20);

    // Randomized strobe rates, occasional bursts and resets.
    for (int r = 0; r < 8; r++) begin
      case (r % 4)
        0:       rate = 60;
        1:       rate = 180;
        2:       rate = 270;
        default: rate = 420;
      endcase
      for (int i = 0; i < 1100; i++) begin
        if ($urandom_range(499) == 0) begin
          for (int b = 0; b < 6; b++) tick(1'b1, SW'($urandom));
        end else begin
          tick(($urandom_range(rate - 1) == 0), SW'($urandom));
        end
      end
      if ($urandom_range(2) == 0) async_reset($urandom_range(4) + 1);
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
